// File: rtl/arith_pkg.sv
// rtl/arith_pkg.sv - key codes, FSM states and sizing shared by the operand entry block
package arith_pkg;

  localparam int OPERAND_W       = 12;
  localparam int MAX_DIGITS      = 3;
  localparam int COOLDOWN_CYCLES = 3;
  localparam int KEY_W           = 5;
  localparam int CNT_W           = $clog2(MAX_DIGITS + 1);
  localparam int CD_W            = $clog2(COOLDOWN_CYCLES + 1);

  localparam logic [KEY_W-1:0] KEY_ENTER     = 5'h10;
  localparam logic [KEY_W-1:0] KEY_FINISH    = 5'h11;
  localparam logic [KEY_W-1:0] KEY_BACKSPACE = 5'h12;

  typedef enum logic [1:0] {
    ENTER_A    = 2'd0,
    ENTER_B    = 2'd1,
    ENTER_NEXT = 2'd2
  } state_t;

  // Codes 0x00-0x0F are hex digits; everything with the top bit set is a command.
  function automatic logic is_digit(input logic [KEY_W-1:0] code);
    return code[KEY_W-1] == 1'b0;
  endfunction

endpackage

// File: rtl/operand_entry_fsm_if.sv
// rtl/operand_entry_fsm_if.sv - keypad input and operand output bundle
interface operand_entry_fsm_if;
  import arith_pkg::*;

  logic                 key_valid;
  logic [KEY_W-1:0]     key_code;
  logic [OPERAND_W-1:0] num1_hex;
  logic [OPERAND_W-1:0] num2_hex;
  logic                 new_input;
  logic                 finish_input;
  logic [OPERAND_W-1:0] entry_value;
  logic [1:0]           phase;

  modport master (
    output key_valid, key_code,
    input  num1_hex, num2_hex, new_input, finish_input, entry_value, phase
  );

  modport slave (
    input  key_valid, key_code,
    output num1_hex, num2_hex, new_input, finish_input, entry_value, phase
  );

endinterface

// File: rtl/hex_entry_reg.sv
// rtl/hex_entry_reg.sv - hex digit shift register with digit count and optional backspace
module hex_entry_reg
  import arith_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load_i,
  input  logic [3:0]           digit_i,
  input  logic                 back_i,
  input  logic                 clear_i,
  output logic [OPERAND_W-1:0] entry_o,
  output logic [CNT_W-1:0]     count_o
);

  logic [OPERAND_W-1:0] entry_q, entry_d;
  logic [CNT_W-1:0]     count_q, count_d;

  // A clear always wins; a full register silently drops further digits.
  always_comb begin
    entry_d = entry_q;
    count_d = count_q;
    if (clear_i) begin
      entry_d = '0;
      count_d = '0;
    end else if (load_i && (count_q != CNT_W'(MAX_DIGITS))) begin
      entry_d = {entry_q[OPERAND_W-5:0], digit_i};
      count_d = count_q + CNT_W'(1);
    end else if (back_i && (count_q != '0)) begin
      entry_d = entry_q >> 4;
      count_d = count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      entry_q <= '0;
      count_q <= '0;
    end else begin
      entry_q <= entry_d;
      count_q <= count_d;
    end
  end

  assign entry_o = entry_q;
  assign count_o = count_q;

endmodule

// File: rtl/operand_entry_fsm.sv
// rtl/operand_entry_fsm.sv - keypad operand entry FSM feeding an accumulating adder
// Optional feature macro: BACKSPACE_EN (enables the 0x12 backspace key).
module operand_entry_fsm
  import arith_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  operand_entry_fsm_if.slave  bus
);

  state_t               state_q, state_d;
  logic [OPERAND_W-1:0] num1_q, num1_d;
  logic [OPERAND_W-1:0] num2_q, num2_d;
  logic                 new_input_q, new_input_d;
  logic                 finish_input_q, finish_input_d;
  logic [CD_W-1:0]      cooldown_q, cooldown_d;

  logic [OPERAND_W-1:0] entry;
  logic [CNT_W-1:0]     count;
  logic                 key_ok, dig_key, enter_key, commit, finish_key, back_key;

  // Keys arriving during the post-pulse cooldown are dropped, not deferred.
  assign key_ok     = bus.key_valid && (cooldown_q == '0);
  assign dig_key    = key_ok && is_digit(bus.key_code);
  assign enter_key  = key_ok && (bus.key_code == KEY_ENTER);
  assign commit     = enter_key && (count != '0);
  assign finish_key = key_ok && (bus.key_code == KEY_FINISH);
`ifdef BACKSPACE_EN
  assign back_key   = key_ok && (bus.key_code == KEY_BACKSPACE);
`else
  assign back_key   = 1'b0;
`endif

  hex_entry_reg u_entry (
    .clk     (clk),
    .rst     (rst),
    .load_i  (dig_key),
    .digit_i (bus.key_code[3:0]),
    .back_i  (back_key),
    .clear_i (commit || finish_key),
    .entry_o (entry),
    .count_o (count)
  );

  always_comb begin
    state_d        = state_q;
    num1_d         = num1_q;
    num2_d         = num2_q;
    new_input_d    = 1'b0;
    finish_input_d = 1'b0;
    cooldown_d     = (cooldown_q != '0) ? cooldown_q - CD_W'(1) : '0;
    if (commit) begin
      case (state_q)
        ENTER_A: begin
          num1_d  = entry;
          state_d = ENTER_B;
        end
        ENTER_B, ENTER_NEXT: begin
          num2_d      = entry;
          new_input_d = 1'b1;
          cooldown_d  = CD_W'(COOLDOWN_CYCLES);
          state_d     = ENTER_NEXT;
        end
        default: state_d = ENTER_A;
      endcase
    end else if (finish_key) begin
      num1_d  = '0;
      num2_d  = '0;
      state_d = ENTER_A;
      // Only a finished accumulation tells the adder; an abandoned pair is silent.
      if (state_q == ENTER_NEXT) begin
        finish_input_d = 1'b1;
        cooldown_d     = CD_W'(COOLDOWN_CYCLES);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= ENTER_A;
      num1_q         <= '0;
      num2_q         <= '0;
      new_input_q    <= 1'b0;
      finish_input_q <= 1'b0;
      cooldown_q     <= '0;
    end else begin
      state_q        <= state_d;
      num1_q         <= num1_d;
      num2_q         <= num2_d;
      new_input_q    <= new_input_d;
      finish_input_q <= finish_input_d;
      cooldown_q     <= cooldown_d;
    end
  end

  assign bus.num1_hex     = num1_q;
  assign bus.num2_hex     = num2_q;
  assign bus.new_input    = new_input_q;
  assign bus.finish_input = finish_input_q;
  assign bus.entry_value  = entry;
  assign bus.phase        = state_q;

endmodule

// File: doc/operand_entry_fsm.md
OPERAND_ENTRY_FSM -- requirements
Module: operand_entry_fsm

Interface
REQ-001 SHALL have port clk, input, 1 bit: single system clock (27 MHz); all logic on its rising edge.
REQ-002 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-003 SHALL have port key_valid, input, 1 bit: one-cycle strobe marking key_code valid.
REQ-004 SHALL have port key_code, input, 5 bits: 0x00-0x0F hex digit, 0x10 ENTER, 0x11 FINISH, 0x12 BACKSPACE, others reserved.
REQ-005 SHALL have port num1_hex, output, 12 bits: first operand for the accumulating adder.
REQ-006 SHALL have port num2_hex, output, 12 bits: second or next operand.
REQ-007 SHALL have port new_input, output, 1 bit: one-cycle pulse, operands ready.
REQ-008 SHALL have port finish_input, output, 1 bit: one-cycle pulse, accumulation ended.
REQ-009 SHALL have port entry_value, output, 12 bits: operand being typed, for display.
REQ-010 SHALL have port phase, output, 2 bits: current state encoding.

Function
REQ-011 SHALL implement states ENTER_A (0), ENTER_B (1) and ENTER_NEXT (2); phase SHALL equal the state.
REQ-012 When key_valid is set with a digit and digit_count < 3, the block SHALL load entry <= {entry[7:0], digit} and increment digit_count on the next edge.
REQ-013 When key_valid is set with a digit and digit_count = 3, the block SHALL ignore the key, leaving entry unchanged.
REQ-014 ENTER with digit_count = 0 SHALL be ignored in every state.
REQ-015 ENTER in ENTER_A SHALL load num1_hex <= entry, clear entry and digit_count, and move to ENTER_B, with no pulse.
REQ-016 ENTER in ENTER_B SHALL load num2_hex <= entry, clear entry, pulse new_input one cycle later, and move to ENTER_NEXT.
REQ-017 ENTER in ENTER_NEXT SHALL load num2_hex <= entry, clear entry, pulse new_input, and stay in ENTER_NEXT; num1_hex SHALL be unchanged.
REQ-018 FINISH in ENTER_NEXT SHALL pulse finish_input, clear entry, num1_hex and num2_hex, and move to ENTER_A.
REQ-019 FINISH in ENTER_A or ENTER_B SHALL clear entry, num1_hex and num2_hex and move to ENTER_A, with no finish_input pulse.
REQ-020 num1_hex and num2_hex SHALL be stable from the new_input pulse until the next ENTER or FINISH takes effect.
REQ-021 After any new_input or finish_input pulse, a 3-cycle cooldown counter SHALL run, during which key_valid is ignored entirely; this keeps downstream SUM/OUTPUT spacing.
REQ-022 new_input and finish_input SHALL never be high in the same cycle, and SHALL never be high on consecutive cycles.
REQ-023 Reserved key codes SHALL be ignored.
REQ-024 key_code SHALL be ignored when key_valid is low.
REQ-025 entry_value SHALL equal the entry register at all times.

Reset
REQ-026 rst SHALL force state ENTER_A and zero all of the following: entry, digit_count, num1_hex, num2_hex, new_input, finish_input and cooldown.
REQ-027 rst mid-entry or during cooldown SHALL abandon the operation and emit no pulse in the reset cycle.
REQ-028 rst SHALL take priority over key_valid.

Configuration
REQ-029 With BACKSPACE_EN defined, BACKSPACE SHALL load entry <= entry >> 4 and decrement digit_count; at digit_count = 0 it SHALL be ignored.
REQ-030 Without BACKSPACE_EN, 0x12 SHALL be treated as a reserved code and ignored.

Structure
REQ-031 Package arith_pkg SHALL hold the key-code constants, the state_t enum, OPERAND_W = 12, MAX_DIGITS = 3 and COOLDOWN_CYCLES = 3.
REQ-032 The digit shift/backspace register with digit_count SHALL be sub-module hex_entry_reg; the FSM, output registers and cooldown SHALL stay in operand_entry_fsm.

Verification
REQ-033 Keys 1,2,3,ENTER,4,5,6,ENTER -> num1_hex=0x123, num2_hex=0x456, one new_input pulse, phase=2.
REQ-034 Then keys 7,ENTER, then FINISH after cooldown -> num2_hex=0x007, new_input pulse, finish_input pulse, phase=0, num1_hex=num2_hex=0.
REQ-035 Keys A,B,C,D,ENTER -> 'D' ignored, num1_hex=0xABC; a bare ENTER is ignored with phase unchanged.
REQ-036 ENTER, then a digit key 1 cycle after the new_input pulse -> digit ignored, entry_value=0; the same key 4 cycles after the pulse is accepted.
REQ-037 Keys F,F,BACKSPACE,1,ENTER with BACKSPACE_EN -> num1_hex=0x0F1; without the macro -> num1_hex=0xFF1.
REQ-038 rst asserted after keys 9,9 in ENTER_B -> all outputs 0, phase=0, no pulses.
